// File: rtl/ifm_packer.sv
// Packs a narrow stream of 9-bit IFM elements into 64-lane ifm_port beats.
// The packing register doubles as the output register; partial beats close on group ends.
module ifm_packer #(
    parameter int IN_ELEMS = 8,
    parameter int ELEM_W   = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_ELEMS*ELEM_W-1:0] s_data,
    input  logic [IN_ELEMS-1:0]        s_keep,
    input  logic                       s_last,
    input  logic                       s_accum_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [64*ELEM_W-1:0]       m_data,
    output logic [63:0]                m_data_element_valid,
    output logic                       m_inter_end,
    output logic                       m_accum_end
);

    localparam int OUT_ELEMS = 64;
    localparam int BEATS     = OUT_ELEMS / IN_ELEMS;
    localparam int SLOT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IN_W      = IN_ELEMS * ELEM_W;
    localparam int OUT_W     = OUT_ELEMS * ELEM_W;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BEATS - 1);

    // Zero the data of every element whose keep bit is clear.
    function automatic logic [IN_W-1:0] mask_elems(input logic [IN_W-1:0] data,
                                                   input logic [IN_ELEMS-1:0] keep);
        logic [IN_W-1:0] res;
        res = {IN_W{1'b0}};
        for (int j = 0; j < IN_ELEMS; j++) begin
            res[j*ELEM_W +: ELEM_W] = keep[j] ? data[j*ELEM_W +: ELEM_W] : {ELEM_W{1'b0}};
        end
        return res;
    endfunction

    logic [OUT_W-1:0]    data_r, data_nxt_s, data_base_s;
    logic [63:0]         ev_r, ev_nxt_s, ev_base_s;
    logic                valid_r, valid_nxt_s;
    logic                inter_r, inter_nxt_s;
    logic                accum_r, accum_nxt_s;
    logic [SLOT_W-1:0]   slot_r, slot_nxt_s;
    logic [IN_W-1:0]     masked_s;
    logic                accept_s, fire_s, close_s;

    assign s_ready  = !valid_r || m_ready;
    assign accept_s = s_valid && s_ready;
    assign fire_s   = valid_r && m_ready;
    assign close_s  = accept_s && ((slot_r == LAST_SLOT) || s_last || s_accum_last);
    assign masked_s = mask_elems(s_data, s_keep);

    // Lane writes: a firing beat is cleared first, then the accepted beat lands in its slot.
    always_comb begin
        data_base_s = fire_s ? {OUT_W{1'b0}} : data_r;
        ev_base_s   = fire_s ? 64'h0 : ev_r;
        data_nxt_s  = data_base_s;
        ev_nxt_s    = ev_base_s;
        for (int b = 0; b < BEATS; b++) begin
            data_nxt_s[b*IN_W +: IN_W] = (accept_s && (slot_r == SLOT_W'(b)))
                                         ? masked_s : data_base_s[b*IN_W +: IN_W];
            ev_nxt_s[b*IN_ELEMS +: IN_ELEMS] = (accept_s && (slot_r == SLOT_W'(b)))
                                               ? s_keep : ev_base_s[b*IN_ELEMS +: IN_ELEMS];
        end
    end

    // Slot, valid and group-end flag updates.
    always_comb begin
        if (accept_s && !close_s) begin
            slot_nxt_s = slot_r + SLOT_W'(1);
        end else if (accept_s || fire_s) begin
            slot_nxt_s = {SLOT_W{1'b0}};
        end else begin
            slot_nxt_s = slot_r;
        end

        if (close_s) begin
            valid_nxt_s = 1'b1;
            inter_nxt_s = s_last | s_accum_last;
            accum_nxt_s = s_accum_last;
        end else if (fire_s) begin
            valid_nxt_s = 1'b0;
            inter_nxt_s = 1'b0;
            accum_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
            inter_nxt_s = inter_r;
            accum_nxt_s = accum_r;
        end
    end

    // Packing/output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {OUT_W{1'b0}};
            ev_r    <= 64'h0;
            valid_r <= 1'b0;
            inter_r <= 1'b0;
            accum_r <= 1'b0;
            slot_r  <= {SLOT_W{1'b0}};
        end else begin
            data_r  <= data_nxt_s;
            ev_r    <= ev_nxt_s;
            valid_r <= valid_nxt_s;
            inter_r <= inter_nxt_s;
            accum_r <= accum_nxt_s;
            slot_r  <= slot_nxt_s;
        end
    end

    assign m_valid              = valid_r;
    assign m_data               = data_r;
    assign m_data_element_valid = ev_r;
    assign m_inter_end          = inter_r;
    assign m_accum_end          = accum_r;

endmodule

// File: tb/tb_ifm_packer.sv
// Scoreboard bench for ifm_packer with IN_ELEMS=8: a lane model predicts each emitted beat.
module tb_ifm_packer;

    localparam int IN = 8;

    typedef struct packed {
        logic [575:0] data;
        logic [63:0]  ev;
        logic         inter;
        logic         accum;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [71:0]   s_data = 72'h0;
    logic [7:0]    s_keep = 8'h0;
    logic          s_last = 1'b0;
    logic          s_accum_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [575:0]  m_data;
    logic [63:0]   m_data_element_valid;
    logic          m_inter_end;
    logic          m_accum_end;

    int            checks = 0;
    int            errors = 0;
    int            w;
    beat_t         sb_q[$];
    logic [575:0]  exp_data = '0;
    logic [63:0]   exp_ev = '0;
    int            exp_slot = 0;

    ifm_packer #(.IN_ELEMS(IN)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .s_accum_last(s_accum_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_data_element_valid(m_data_element_valid),
        .m_inter_end(m_inter_end), .m_accum_end(m_accum_end)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Output side of the scoreboard: compare every fired beat against the oldest prediction.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output got ev %h exp none", m_data_element_valid);
            end else begin
                e = sb_q.pop_front();
                checks += 4;
                if (m_data !== e.data) begin
                    errors++; $display("FAIL out_data got %h exp %h", m_data, e.data);
                end
                if (m_data_element_valid !== e.ev) begin
                    errors++; $display("FAIL out_ev got %h exp %h", m_data_element_valid, e.ev);
                end
                if (m_inter_end !== e.inter) begin
                    errors++; $display("FAIL out_inter got %b exp %b", m_inter_end, e.inter);
                end
                if (m_accum_end !== e.accum) begin
                    errors++; $display("FAIL out_accum got %b exp %b", m_accum_end, e.accum);
                end
            end
        end
    end

    function automatic logic [71:0] lanes(input int base);
        logic [71:0] r;
        for (int j = 0; j < IN; j++) r[j*9 +: 9] = 9'(base + j);
        return r;
    endfunction

    task automatic model_reset();
        exp_data = '0; exp_ev = '0; exp_slot = 0;
    endtask

    // Drive one input beat until accepted; the model is updated on the accepting edge.
    task automatic send(input logic [71:0] d, input logic [7:0] k, input logic l,
                        input logic a, output int waits);
        bit acc;
        beat_t b;
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; s_accum_last = a;
        waits = 0; acc = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            if (s_ready === 1'b1) acc = 1'b1;
            else waits++;
            @(posedge clk);
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout got no accept exp accept within 50 cycles");
        end else begin
            for (int j = 0; j < IN; j++) begin
                exp_data[(exp_slot*IN + j)*9 +: 9] = k[j] ? d[j*9 +: 9] : 9'h0;
                exp_ev[exp_slot*IN + j] = k[j];
            end
            if (exp_slot == 64/IN - 1 || l || a) begin
                b.data = exp_data; b.ev = exp_ev; b.inter = l | a; b.accum = a;
                sb_q.push_back(b);
                model_reset();
            end else begin
                exp_slot++;
            end
        end
        #1;
        s_valid = 1'b0; s_last = 1'b0; s_accum_last = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL %s_drain got %0d pending exp 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", m_valid); end
        if (m_data !== 576'h0 || m_data_element_valid !== 64'h0) begin
            errors++; $display("FAIL rst_data got ev %h exp 0", m_data_element_valid);
        end
        if ({m_inter_end, m_accum_end} !== 2'b00) begin
            errors++; $display("FAIL rst_flags got %b%b exp 00", m_inter_end, m_accum_end);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_beat();
        for (int b = 0; b < 8; b++) begin
            send(lanes(8*b), 8'hFF, 1'b0, 1'b0, w);
            if (b == 6) begin
                checks++;
                if (m_valid !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", m_valid); end
            end
        end
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL full_latency got %b exp 1", m_valid); end
        wait_drain();
        check_drained("full");
    endtask

    task automatic test_partial_last();
        for (int b = 0; b < 3; b++) send(lanes(10*b + 1), 8'hFF, (b == 2), 1'b0, w);
        wait_drain();
        send(lanes(77), 8'h00, 1'b1, 1'b0, w);
        wait_drain();
        check_drained("partial");
    endtask

    task automatic test_accum_last();
        send(lanes(30), 8'hFF, 1'b0, 1'b0, w);
        send(lanes(40), 8'h0F, 1'b0, 1'b1, w);
        wait_drain();
        check_drained("accum");
    endtask

    task automatic test_stall();
        m_ready = 1'b0;
        send(lanes(200), 8'hFF, 1'b1, 1'b0, w);
        s_valid = 1'b1; s_data = lanes(300); s_keep = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks += 3;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", s_ready); end
            if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", m_valid); end
            if (m_data !== sb_q[0].data || m_data_element_valid !== sb_q[0].ev
                || m_inter_end !== 1'b1) begin
                errors++; $display("FAIL stall_hold got ev %h exp %h", m_data_element_valid, sb_q[0].ev);
            end
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        send(lanes(300), 8'hFF, 1'b1, 1'b0, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL stall_release_waits got %0d exp 0", w); end
        wait_drain();
        check_drained("stall");
    endtask

    task automatic test_keep_mask();
        for (int b = 0; b < 8; b++) send(lanes(8*b + 100), 8'b1010_0101, 1'b0, 1'b0, w);
        wait_drain();
        check_drained("keep");
    endtask

    task automatic test_back_to_back();
        int total;
        total = 0;
        for (int b = 0; b < 16; b++) begin
            send(lanes(3*b + 5), 8'hFF, 1'b0, 1'b0, w);
            total += w;
        end
        checks++;
        if (total != 0) begin errors++; $display("FAIL b2b_waits got %0d exp 0", total); end
        wait_drain();
        check_drained("b2b");
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        for (int b = 0; b < 8; b++) send(lanes(8*b + 64), 8'hFF, 1'b0, 1'b0, w);
        #3 rst_n = 1'b0;
        #1;
        checks += 3;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL arst_valid got %b/%b exp 0/1", m_valid, s_ready);
        end
        if (m_data !== 576'h0 || m_data_element_valid !== 64'h0) begin
            errors++; $display("FAIL arst_data got ev %h exp 0", m_data_element_valid);
        end
        if ({m_inter_end, m_accum_end} !== 2'b00) begin
            errors++; $display("FAIL arst_flags got %b%b exp 00", m_inter_end, m_accum_end);
        end
        sb_q.delete(); model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; m_ready = 1'b1;
        for (int b = 0; b < 4; b++) send(lanes(8*b + 128), 8'hFF, 1'b0, 1'b0, w);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (m_data_element_valid !== 64'h0 || m_data !== 576'h0) begin
            errors++; $display("FAIL arst_partial got ev %h exp 0", m_data_element_valid);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int b = 0; b < 8; b++) send(lanes(8*b + 300), 8'hFF, 1'b0, 1'b0, w);
        wait_drain();
        check_drained("arst");
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_partial_last();
        test_accum_last();
        test_stall();
        test_keep_mask();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifm_packer.md
Name: ifm_packer

Overview:
- Input-feature-map packer directly upstream of the IFM consumer port.
- Accepts a narrow element stream of IN_ELEMS 9-bit elements per beat from the IFM fetch path.
- Assembles 64-element beats and presents them field-for-field as tx_pkg::ifm_port: valid/ready, 576-bit data, 64-bit data_element_valid, inter_end, accum_end.
- Closes partial beats on group boundaries and marks the unused lanes invalid.

Parameters:
IN_ELEMS, 8, elements per input beat; legal values are 1, 2, 4, 8, 16, 32, 64
ELEM_W, 9, element width in bits; fixed by the port format, do not override
BEATS, 64/IN_ELEMS (derived localparam), input beats per full output beat

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  upstream beat valid
s_ready  output  1  upstream beat accepted when s_valid&s_ready
s_data  input  IN_ELEMS*9  element j at bits [9j+8:9j]
s_keep  input  IN_ELEMS  per-element valid
s_last  input  1  beat ends the current inter (partial-sum) group
s_accum_last  input  1  beat ends the accumulation; implies s_last
m_valid  output  1  ifm_port.valid
m_ready  input  1  ifm_port.ready
m_data  output  576  ifm_port.data; lane i at bits [9i+8:9i]
m_data_element_valid  output  64  ifm_port.data_element_valid
m_inter_end  output  1  ifm_port.inter_end
m_accum_end  output  1  ifm_port.accum_end

Behaviour:
- Datapath state:
  - Single packing register, which is also the output register.
  - Slot counter slot ∈ [0, BEATS-1].
  - Flags inter_end and accum_end.
- Handshake:
  - s_ready = !m_valid || m_ready (combinational).
  - Input accept: s_valid & s_ready.
  - Output fire: m_valid & m_ready.
  - m_valid is registered.
  - While m_valid=1 and m_ready=0, m_data, m_data_element_valid, m_inter_end and m_accum_end hold stable.
- On accept:
  - Write s_data into lanes [slot*IN_ELEMS, slot*IN_ELEMS+IN_ELEMS-1].
  - Write s_keep into the same bits of m_data_element_valid.
  - Lanes whose keep bit is 0 have their data forced to 0.
- Beat close:
  - Condition: an accept with slot==BEATS-1, or s_last=1, or s_accum_last=1.
  - m_valid=1 in the next cycle. Latency is 1 cycle from the closing accept.
  - slot returns to 0.
  - m_inter_end = s_last | s_accum_last. m_accum_end = s_accum_last.
  - A full beat without s_last has both flags 0.
- Non-closing accept: slot increments; m_valid stays 0.
- Simultaneous fire and accept:
  - The register is cleared: all data 0, all element_valid 0, flags 0.
  - The new beat is written into slot 0 in the same edge.
  - If that beat also closes (IN_ELEMS=64, or s_last=1), m_valid remains 1.
- Fire without accept:
  - Register cleared, m_valid=0, slot=0.
- Unwritten lanes of a partial beat are data 0 and element_valid 0.
- A closing beat with s_keep all-zero is still emitted; it may have element_valid all 0 and inter_end=1.
- Throughput:
  - 1 input beat per cycle sustained.
  - An output bubble never throttles input, except while m_valid=1 & m_ready=0.
- Reset (any time, including mid-beat or mid-stall):
  - m_valid=0, m_data=0, m_data_element_valid=0, m_inter_end=0, m_accum_end=0, slot=0.
  - A partial beat is discarded.
  - s_ready is 1 once rst_n deasserts.
- Inputs are ignored when not accepted. s_data, s_keep, s_last and s_accum_last are sampled only on accept.

Test Plan:
1. IN_ELEMS=8. 8 accepts, s_keep=8'hFF, lane k value = k, no last -> m_valid 1 cycle after the 8th accept; lanes 0..63 = 0..63; element_valid = all ones; inter_end=0, accum_end=0.
2. 3 accepts, s_last=1 on the 3rd -> element_valid = 64'h0000_0000_00FF_FFFF; lanes 24..63 data=0; inter_end=1, accum_end=0; next beat starts at slot 0.
3. Closing beat with s_accum_last=1, s_last=0 -> inter_end=1, accum_end=1.
4. Beat closed, m_ready=0 for 5 cycles, s_valid=1 throughout -> s_ready=0 for 5 cycles; outputs bit-stable. When m_ready rises, the fire and an accept occur in the same cycle; the next output has the new data in lanes 0..7 and zero/invalid in lanes 8..63.
5. s_keep=8'b1010_0101 on every beat of a full output -> element_valid = {8{8'hA5}}; masked lanes data=0.
6. Assert rst_n=0 after 4 accepts -> all outputs 0 asynchronously. After release, 8 accepts produce one output containing only post-reset data.
